// File: rtl/mod5_pkg.sv
// Shared types, constants and the one-bit modulo-5 step for the mod5 scheduler.
package mod5_pkg;

    localparam int MOD   = 5;
    localparam int REM_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t RESP  = 2'd2;

    // Next remainder after appending one bit (MSB-first): (2*rem + din) mod 5.
    // rem is always 0..4, so 2*rem+din is 0..9 and a single conditional subtract
    // is enough.
    function automatic logic [REM_W-1:0] mod5_step(input logic [REM_W-1:0] rem,
                                                   input logic             din);
        logic [REM_W:0] dbl;
        logic [REM_W:0] red;
        dbl = {rem, din};
        red = (int'(dbl) >= MOD) ? (dbl - (REM_W+1)'(MOD)) : dbl;
        return red[REM_W-1:0];
    endfunction

endpackage

// File: rtl/mod5_serial_core.sv
// Bit-serial modulo-5 engine: holds the operand, shifts it out MSB first and
// accumulates the remainder, flagging the final shift edge with done.
module mod5_serial_core
    import mod5_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic [WIDTH-1:0] operand,
    output logic [REM_W-1:0] rem_next,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sreg;
    logic [REM_W-1:0] rem;
    logic [CNT_W-1:0] bitcnt;

    assign rem_next = mod5_step(rem, sreg[WIDTH-1]);
    assign done     = shift_en && (bitcnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            operand <= '0;
            rem     <= '0;
            bitcnt  <= '0;
        end else if (load) begin
            sreg    <= load_data;
            operand <= load_data;
            rem     <= '0;
            bitcnt  <= CNT_W'(WIDTH - 1);
        end else if (shift_en) begin
            rem  <= rem_next;
            sreg <= sreg << 1;
            if (bitcnt != '0) begin
                bitcnt <= bitcnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod5_rr_scheduler.sv
// Round-robin scheduler sharing one serial mod-5 engine between NREQ requesters.
// Optional MOD5_STATS_EN adds saturating response/hit counters.
//
// state | meaning
// IDLE  | arbitrate; grant lowest-priority-adjusted valid requester
// SHIFT | engine consumes one operand bit per edge, WIDTH edges total
// RESP  | registered response presented until rsp_ready
module mod5_rr_scheduler
    import mod5_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [REM_W-1:0]         rsp_rem,
    output logic                     rsp_multiple
`ifdef MOD5_STATS_EN
    ,
    output logic [15:0]              stat_total,
    output logic [15:0]              stat_hits
`endif
);

    localparam int ID_W = $clog2(NREQ);

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_valid;
    logic [ID_W-1:0]  next_ptr;
    logic             accept;
    logic             shift_en;
    logic [WIDTH-1:0] core_operand;
    logic [REM_W-1:0] core_rem_next;
    logic             core_done;

    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // Explicit wrap so non-power-of-two NREQ never yields an out-of-range pointer.
    assign next_ptr = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign accept   = rst_n && (state == IDLE) && grant_valid;
    assign shift_en = (state == SHIFT);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    mod5_serial_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (req_data[grant_idx*WIDTH +: WIDTH]),
        .shift_en  (shift_en),
        .operand   (core_operand),
        .rem_next  (core_rem_next),
        .done      (core_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id_q         <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_rem      <= '0;
            rsp_multiple <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        id_q   <= grant_idx;
                        rr_ptr <= next_ptr;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (core_done) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= id_q;
                        rsp_data     <= core_operand;
                        rsp_rem      <= core_rem_next;
                        rsp_multiple <= (core_rem_next == '0);
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MOD5_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total <= '0;
            stat_hits  <= '0;
        end else if (rsp_fire) begin
            if (stat_total != 16'hFFFF) begin
                stat_total <= stat_total + 16'd1;
            end
            if (rsp_multiple && (stat_hits != 16'hFFFF)) begin
                stat_hits <= stat_hits + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mod5_rr_scheduler.sv
// Directed self-checking bench for mod5_rr_scheduler (NREQ=4, WIDTH=8).
// Stats outputs are checked only when MOD5_STATS_EN is defined.
module tb_mod5_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_id;
    logic [WIDTH-1:0]        rsp_data;
    logic [2:0]              rsp_rem;
    logic                    rsp_multiple;
`ifdef MOD5_STATS_EN
    logic [15:0]             stat_total;
    logic [15:0]             stat_hits;
`endif

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    mod5_rr_scheduler #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_rem      (rsp_rem),
        .rsp_multiple (rsp_multiple)
`ifdef MOD5_STATS_EN
        ,
        .stat_total   (stat_total),
        .stat_hits    (stat_hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single request with rsp_ready held high; returns at a negedge with the response visible.
    task automatic do_req(input int id, input logic [7:0] data);
        int n;
        @(negedge clk);
        req_valid[id] = 1'b1;
        req_data[id*WIDTH +: WIDTH] = data;
        #1;
        n = 0;
        while (!req_ready[id] && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("req_grant_timeout", 32'(n < 30), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", 32'(n < 30), 1);
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_data", 32'(rsp_data), 32'(data));
        check("rsp_rem", 32'(rsp_rem), 32'(data % 5));
        check("rsp_multiple", 32'(rsp_multiple), 32'((data % 5) == 0));
    endtask

    initial begin
        int n;
        int last_cyc;
        int exp_g;
        bit seen;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;

        // Reset values, and req_ready suppressed even with requests pending.
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_rem", 32'(rsp_rem), 0);
        check("rst_rsp_multiple", 32'(rsp_multiple), 0);
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 2, data 25, latency of 8 edges.
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_data[2*WIDTH +: WIDTH] = 8'd25;
        #1;
        check("t1_ready_onehot", 32'(req_ready), 32'b0100);
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("t1_ready_pulse", 32'(req_ready), 0);
        n = 1;
        seen = 1'b0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
            else n++;
        end
        check("t1_latency", 32'(n), 8);
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 1);
        check("t1_rsp_id", 32'(rsp_id), 2);
        check("t1_rsp_rem", 32'(rsp_rem), 0);
        check("t1_rsp_multiple", 32'(rsp_multiple), 1);
        check("t1_rsp_data", 32'(rsp_data), 25);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t1_rsp_drop", 32'(rsp_valid), 0);

        // Full operand sweep through requester 0.
        for (int v = 0; v < 256; v++) begin
            do_req(0, 8'(v));
        end
        @(negedge clk);

        // Fairness with all four requesters continuously valid.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = 8'(10 + i);
        end
        req_valid = 4'hF;
        last_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            exp_g = k % NREQ;
            #1;
            n = 0;
            while (req_ready == '0 && n < 30) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("rr_grant_timeout", 32'(n < 30), 1);
            check("rr_grant", 32'(req_ready), 32'(1 << exp_g));
            if (k > 0) check("rr_spacing", 32'(cyc - last_cyc), 10);
            last_cyc = cyc;
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("rr_rsp_timeout", 32'(n < 30), 1);
            check("rr_rsp_id", 32'(rsp_id), 32'(exp_g));
            check("rr_rsp_rem", 32'(rsp_rem), 32'((10 + exp_g) % 5));
            if (k < 4) @(negedge clk);
        end
        req_valid = '0;

        // Backpressure: requester 1, data 7, rsp_ready low for 20 cycles.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid[1] = 1'b1;
        req_data[1*WIDTH +: WIDTH] = 8'd7;
        #1;
        check("bp_grant", 32'(req_ready), 32'b0010);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_timeout", 32'(n < 30), 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 1);
            check("bp_hold_rem", 32'(rsp_rem), 2);
            check("bp_no_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid), 0);
        check("bp_idle_grant", 32'(req_ready), 32'b1000);
        req_valid[3] = 1'b0;
        #1;
        check("bp_withdraw", 32'(req_ready), 0);

        // Reset in the middle of SHIFT, bitcnt at 3.
        @(negedge clk);
        req_valid[3] = 1'b1;
        req_data[3*WIDTH +: WIDTH] = 8'd100;
        #1;
        check("mr_grant", 32'(req_ready), 32'b1000);
        @(posedge clk);
        @(negedge clk);
        req_valid[3] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rsp_valid", 32'(rsp_valid), 0);
        check("mr_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("mr_no_response", 32'(seen), 0);
        req_valid = 4'hF;
        #1;
        check("mr_ptr_zero", 32'(req_ready), 32'b0001);
        req_valid = '0;

        // Boundary operands after the reset.
        do_req(0, 8'd254);
        do_req(1, 8'd255);
        do_req(2, 8'd0);
        @(negedge clk);

`ifdef MOD5_STATS_EN
        do_reset();
        check("st_reset_total", 32'(stat_total), 0);
        check("st_reset_hits", 32'(stat_hits), 0);
        do_req(0, 8'd0);
        do_req(0, 8'd3);
        do_req(0, 8'd5);
        do_req(0, 8'd9);
        do_req(0, 8'd10);
        @(negedge clk);
        check("st_total", 32'(stat_total), 5);
        check("st_hits", 32'(stat_hits), 3);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mod5_rr_scheduler.md
Name: mod5_rr_scheduler

Overview:
Shares one bit-serial modulo-5 engine between NREQ requesters and returns for each request whether the operand is a multiple of 5, plus its remainder. Requesters use valid/ready handshakes and are granted round-robin. There is one response channel, tagged with the requester ID. The existing combinational Multiple_of_5 checker is the golden model in verification.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand width in bits (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester request valid
req_data  in  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  NREQ  one-hot accept; at most one bit high
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  $clog2(NREQ)  requester index of the response
rsp_data  out  WIDTH  echoed operand
rsp_rem  out  3  operand mod 5 (0..4)
rsp_multiple  out  1  1 iff rsp_rem==0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_rem=0, rsp_multiple=0.
  - req_ready all 0 while in reset.
  - Reset mid-operation discards the in-flight request; no response is produced for it.
- State IDLE:
  - Grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready[g]=1 combinationally in IDLE only; all other bits 0.
  - On the edge with req_valid[g]&req_ready[g]:
    - capture operand into the shift register and g into the ID register;
    - rem←0, bitcnt←WIDTH-1;
    - rr_ptr←(g+1) mod NREQ;
    - state→SHIFT.
  - No req_valid: stay IDLE, rr_ptr unchanged.
- State SHIFT:
  - Each edge consumes one operand bit, MSB first: rem←(2*rem+bit) mod 5, using the table rem 0..4 × bit 0/1. No divider.
  - When bitcnt==0 on that edge: state→RESP; otherwise bitcnt−1.
  - req_ready all 0.
  - Exactly WIDTH edges in SHIFT.
- State RESP:
  - rsp_valid=1; rsp_* are stable and registered.
  - On the edge with rsp_ready=1: state→IDLE, rsp_valid←0.
  - Otherwise hold indefinitely (backpressure).
  - req_ready all 0.
- Latency:
  - rsp_valid rises WIDTH edges after the accepting edge.
  - Minimum request spacing is WIDTH+2 cycles: 1 IDLE + WIDTH SHIFT + 1 RESP with rsp_ready=1.
- Handshake rules:
  - Requesters hold req_valid/req_data stable until accepted.
  - A requester may drop req_valid before being granted; nothing is recorded.
  - rsp_ready may be held high permanently.
- Fairness: after servicing requester g, g has the lowest priority. With all requesters valid, grants rotate 0,1,2,3,0,…
- Widths: rem is 3 bits and never exceeds 4. rsp_data is an exact copy of the captured operand.
- Boundaries:
  - Operand 0 → rem 0, multiple 1.
  - Operand 255 (WIDTH=8) → rem 0, multiple 1.
  - Operand 254 → rem 4, multiple 0.
  - NREQ not a power of 2: the rr_ptr wrap is explicit, and rsp_id never exceeds NREQ-1.

Optional Feature:
MOD5_STATS_EN
- Defined:
  - Adds outputs stat_total[15:0] and stat_hits[15:0], both reset to 0.
  - On every response handshake (rsp_valid&rsp_ready), stat_total increments; stat_hits also increments if rsp_multiple.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mod5_pkg:
  - state typedef {IDLE, SHIFT, RESP};
  - constant MOD=5;
  - REM_W=3;
  - function mod5_step(rem, bit) returning the next remainder.
- Sub-module mod5_serial_core:
  - owns the operand shift register, bitcnt, rem and the done pulse;
  - the top holds the arbiter, FSM, ID register and response registers.

Test Plan:
- Reset, then a single request from requester 2 with data=25 → req_ready[2] pulses for 1 cycle; rsp_valid rises 8 edges later; rsp_id=2, rem=0, multiple=1.
- Sweep 0..255 through requester 0, rsp_ready=1 → each response matches Multiple_of_5 and in%5; 256 responses, zero errors.
- All 4 requesters valid continuously with data 10,11,12,13 → grant order 0,1,2,3,0; rem sequence 0,1,2,3; each request spaced 10 cycles.
- rsp_ready=0 for 20 cycles during RESP with data=7 → rsp_valid held, rem=2 stable, no req_ready asserted; release → IDLE the next cycle.
- rst_n pulsed low mid-SHIFT (bitcnt=3) → rsp_valid=0 immediately, no response emitted, rr_ptr=0; the next request is granted normally.
- With MOD5_STATS_EN defined: 5 requests with data 0,3,5,9,10 → stat_total=5, stat_hits=3; forcing 65536 hits → stat_hits stays 16'hFFFF.
